// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that decides, in the ID stage, whether the
// current instruction may issue or must be held back behind a pending producer.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int LONG_LAT = 4,
  parameter int BR_EXTRA = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [AW-1:0]     id_rs1,
  input  logic [AW-1:0]     id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic              id_reg_write,
  input  logic [AW-1:0]     id_rd,
  input  logic [1:0]        id_lat_class,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam int CW = $clog2(LONG_LAT + BR_EXTRA + 1);
  localparam int LW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

  localparam logic [CW-1:0] V_ALU   = CW'(BR_EXTRA);
  localparam logic [CW-1:0] V_LOAD  = CW'(LOAD_LAT + BR_EXTRA);
  localparam logic [CW-1:0] V_LONG  = CW'(LONG_LAT + BR_EXTRA);
  localparam logic [LW-1:0] LB_INIT = LW'(LONG_LAT - 1);
  localparam logic [1:0]    CLS_LOAD = 2'd1;
  localparam logic [1:0]    CLS_LONG = 2'd2;

  // Cycles until each register's value is usable by a branch in ID.
  // A non-branch consumer can read it BR_EXTRA cycles earlier (via EX forwarding).
  logic [CW-1:0] cnt [1:NREG-1];
  logic [LW-1:0] long_busy;

  logic [CW-1:0] rs1_cnt;
  logic [CW-1:0] rs2_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] v_issue;
  logic [CW-1:0] raw_thr;
  logic          raw1;
  logic          raw2;
  logic          waw;
  logic          struct_haz;
  logic          live;
  logic          stall;
  logic          issue;
  logic          load_rd;

  // Register 0 is absent from the array, so every lookup of x0 reads zero.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    for (int r = 1; r < NREG; r++) begin
      if (id_rs1 == AW'(r)) rs1_cnt = cnt[r];
      if (id_rs2 == AW'(r)) rs2_cnt = cnt[r];
      if (id_rd  == AW'(r)) rd_cnt  = cnt[r];
    end
  end

  always_comb begin
    case (id_lat_class)
      CLS_LOAD: v_issue = V_LOAD;
      CLS_LONG: v_issue = V_LONG;
      default:  v_issue = V_ALU;
    endcase
  end

  // Stall handshake: the ID instruction moves on only when stall is low; while
  // stall is high the front end holds PC/IF_ID and ID re-presents identical
  // inputs, and ID/EX receives a bubble. An instruction issues exactly once.
  always_comb begin
    raw_thr    = id_is_branch ? '0 : V_ALU;
    raw1       = id_use_rs1 && (rs1_cnt > raw_thr);
    raw2       = id_use_rs2 && (rs2_cnt > raw_thr);
    waw        = id_reg_write && (id_rd != '0) && (rd_cnt > v_issue);
    struct_haz = (id_lat_class == CLS_LONG) && (long_busy != '0);
    live       = id_valid && !id_flush;
    stall      = live && (raw1 || raw2 || waw || struct_haz);
    issue      = live && !stall;
    load_rd    = issue && id_reg_write && (id_rd != '0);
  end

  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign id_ex_flush = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (load_rd && (id_rd == AW'(r))) begin
          cnt[r] <= v_issue;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  // The long-op unit is not pipelined; it is occupied for LONG_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_busy <= '0;
    end else if (issue && (id_lat_class == CLS_LONG)) begin
      long_busy <= LB_INIT;
    end else if (long_busy != '0) begin
      long_busy <= long_busy - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: producer issues in cycle 0, consumer
// is held in ID and its per-cycle stall pattern is compared against hand values.
module tb_hazard_scoreboard;

  localparam int AW     = 5;
  localparam int STAT_W = 16;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic              id_flush;
  logic [AW-1:0]     id_rs1;
  logic [AW-1:0]     id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_is_branch;
  logic              id_reg_write;
  logic [AW-1:0]     id_rd;
  logic [1:0]        id_lat_class;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_flush;
  logic [STAT_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_flush     (id_flush),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_branch (id_is_branch),
    .id_reg_write (id_reg_write),
    .id_rd        (id_rd),
    .id_lat_class (id_lat_class),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_flush  (id_ex_flush),
    .stall_cycles (stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_flush     = 1'b0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_use_rs1   = 1'b0;
    id_use_rs2   = 1'b0;
    id_is_branch = 1'b0;
    id_reg_write = 1'b0;
    id_rd        = '0;
    id_lat_class = 2'd0;
  endtask

  task automatic present(input logic [AW-1:0] rs1, input logic u1,
                         input logic [AW-1:0] rs2, input logic u2,
                         input logic br, input logic rw,
                         input logic [AW-1:0] rd, input logic [1:0] cls);
    id_valid     = 1'b1;
    id_flush     = 1'b0;
    id_rs1       = rs1;
    id_use_rs1   = u1;
    id_rs2       = rs2;
    id_use_rs2   = u2;
    id_is_branch = br;
    id_reg_write = rw;
    id_rd        = rd;
    id_lat_class = cls;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Producer with no sources: must issue without stalling in cycle 0.
  task automatic issue_prod(input string tag, input logic [AW-1:0] rd, input logic [1:0] cls);
    present('0, 1'b0, '0, 1'b0, 1'b0, 1'b1, rd, cls);
    #1;
    check({tag, "_c0"}, {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b110);
    tick();
  endtask

  // Consumer already presented; one expected stall bit per cycle from exp_q.
  task automatic drain(input string tag);
    logic [0:0] e;
    int n;
    n = 1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      #1;
      check($sformatf("%s_c%0d", tag, n), {29'd0, pc_write, if_id_write, id_ex_flush},
            e[0] ? 32'b001 : 32'b110);
      tick();
      n++;
    end
    idle();
  endtask

  task automatic push_pat(input int stalls);
    for (int i = 0; i < stalls; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    present(5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 2'd2);
    #2;
    check("reset_outs", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b110);
    check("reset_stat", 32'(stall_cycles), 32'd0);

    // load x6 -> add x7,x6,x1
    reset_dut();
    issue_prod("ld_add", 5'd6, 2'd1);
    present(5'd6, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd7, 2'd0);
    push_pat(1);
    drain("ld_add");
    check("ld_add_stat", 32'(stall_cycles), 32'd1);

    // ALU x5 -> beq x5,x0
    reset_dut();
    issue_prod("alu_br", 5'd5, 2'd0);
    present(5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0);
    push_pat(1);
    drain("alu_br");
    check("alu_br_stat", 32'(stall_cycles), 32'd1);

    // load x5 -> beq x5,x0
    reset_dut();
    issue_prod("ld_br", 5'd5, 2'd1);
    present(5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0);
    push_pat(2);
    drain("ld_br");
    check("ld_br_stat", 32'(stall_cycles), 32'd2);

    // long x8 -> add x12,x8,x2
    reset_dut();
    issue_prod("lng_add", 5'd8, 2'd2);
    present(5'd8, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd12, 2'd0);
    push_pat(4);
    drain("lng_add");
    check("lng_add_stat", 32'(stall_cycles), 32'd4);

    // long x8 -> beq x3,x8 (dependency on rs2)
    reset_dut();
    issue_prod("lng_br", 5'd8, 2'd2);
    present(5'd3, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0);
    push_pat(5);
    drain("lng_br");
    check("lng_br_stat", 32'(stall_cycles), 32'd5);

    // long x9 -> independent long x10: structural hazard
    reset_dut();
    issue_prod("lng_lng", 5'd9, 2'd2);
    present(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd10, 2'd2);
    push_pat(3);
    drain("lng_lng");
    check("lng_lng_stat", 32'(stall_cycles), 32'd3);

    // long x11 -> load x11: WAW
    reset_dut();
    issue_prod("waw", 5'd11, 2'd2);
    present('0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'd11, 2'd1);
    push_pat(3);
    drain("waw");
    check("waw_stat", 32'(stall_cycles), 32'd3);

    // writes to x0 are never tracked
    reset_dut();
    issue_prod("x0_ld", 5'd0, 2'd1);
    present(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 2'd1);
    push_pat(0);
    drain("x0_use");
    check("x0_stat", 32'(stall_cycles), 32'd0);

    // both sources on the same busy register: one hazard
    reset_dut();
    issue_prod("dup", 5'd6, 2'd1);
    present(5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd7, 2'd0);
    push_pat(1);
    drain("dup");
    check("dup_stat", 32'(stall_cycles), 32'd1);

    // invalid ID slot never stalls
    reset_dut();
    issue_prod("inv", 5'd8, 2'd2);
    present(5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 2'd2);
    id_valid = 1'b0;
    #1;
    check("inv_nostall", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b110);
    tick();
    idle();

    // flush during RAW: no stall, no load; decrements continue
    reset_dut();
    issue_prod("flush", 5'd8, 2'd2);
    present(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 2'd1);
    id_flush = 1'b1;
    #1;
    check("flush_nostall", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b110);
    tick();
    present(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 2'd0);
    push_pat(3);
    drain("flush_after");
    check("flush_stat", 32'(stall_cycles), 32'd3);

    // flushed load must not track its destination
    reset_dut();
    present('0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'd13, 2'd1);
    id_flush = 1'b1;
    tick();
    present(5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd14, 2'd0);
    push_pat(0);
    drain("flush_noload");

    // reset asserted mid long-op stall
    reset_dut();
    issue_prod("rst_mid", 5'd8, 2'd2);
    present(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 2'd0);
    #1;
    check("rst_mid_c1", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b001);
    tick();
    #1;
    check("rst_mid_c2", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b001);
    check("rst_mid_stat_pre", 32'(stall_cycles), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b110);
    check("rst_mid_stat", 32'(stall_cycles), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_after", {29'd0, pc_write, if_id_write, id_ex_flush}, 32'b110);
    tick();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
